multicycle_control_fsm: RTL and testbench

//  Multi-cycle successor to the single-cycle main decoder: sequences each RV32I instruction over several cycles, sharing one ALU and one memory port.

---
 rtl/multicycle_control_fsm.sv | 183 ++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: steps lw/sw/R/I/beq/jal through shared ALU and memory
// phases, with a memory-stall timeout, sticky trap on illegal opcodes and a retired counter.
module multicycle_control_fsm #(
    parameter int WAIT_LIMIT = 15,
    parameter int RET_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             adr_src,
    output logic             ir_write,
    output logic             mem_write,
    output logic             reg_write,
    output logic             pc_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       imm_src,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [RET_W-1:0] retired
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam int WAIT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
    } stateT;

    stateT             state, nextState;
    logic [WAIT_W-1:0] waitCnt;
    logic              memReqRaw, irWriteRaw, memWriteRaw, regWriteRaw, pcWriteRaw;
    logic              stalled, retire;
    logic [1:0]        entryCause;

    always_comb begin
        nextState   = state;
        memReqRaw   = 1'b0;
        adr_src     = 1'b0;
        irWriteRaw  = 1'b0;
        memWriteRaw = 1'b0;
        regWriteRaw = 1'b0;
        pcWriteRaw  = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        entryCause  = 2'b00;
        case (state)
            FETCH: begin
                memReqRaw  = 1'b1;
                irWriteRaw = mem_ready;
                pcWriteRaw = mem_ready;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) nextState = DECODE;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: nextState = MEMADR;
                    OP_R:         nextState = EXECR;
                    OP_I:         nextState = EXECI;
                    OP_BEQ:       nextState = BEQ;
                    OP_JAL:       nextState = JAL;
                    default: begin
                        nextState  = TRAP;
                        entryCause = 2'b01;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                nextState = (op == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                memReqRaw = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) nextState = MEMWB;
            end
            MEMWB: begin
                result_src  = 2'b01;
                regWriteRaw = 1'b1;
                nextState   = FETCH;
            end
            MEMWRITE: begin
                memReqRaw   = 1'b1;
                adr_src     = 1'b1;
                memWriteRaw = mem_ready;
                if (mem_ready) nextState = FETCH;
            end
            EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                nextState = ALUWB;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                nextState = ALUWB;
            end
            ALUWB: begin
                regWriteRaw = 1'b1;
                nextState   = FETCH;
            end
            BEQ: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                pcWriteRaw = zero;
                nextState  = FETCH;
            end
            JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pcWriteRaw = 1'b1;
                nextState  = ALUWB;
            end
            default: nextState = TRAP;
        endcase

        // A stall that reaches the limit traps, but a same-cycle mem_ready completes the access instead
        stalled = memReqRaw && !mem_ready;
        if ((WAIT_LIMIT != 0) && stalled && (waitCnt == WAIT_W'(WAIT_LIMIT))) begin
            nextState  = TRAP;
            entryCause = 2'b10;
        end

        retire = (nextState == FETCH) &&
                 ((state == MEMWB) || (state == MEMWRITE) || (state == ALUWB) || (state == BEQ));
    end

    always_comb begin
        imm_src = 2'b00;
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    // Reset suppresses every enable so an aborted instruction leaves no partial write behind
    assign mem_req   = memReqRaw   && rst;
    assign ir_write  = irWriteRaw  && rst;
    assign mem_write = memWriteRaw && rst;
    assign reg_write = regWriteRaw && rst;
    assign pc_write  = pcWriteRaw  && rst;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= FETCH;
            waitCnt    <= '0;
            retired    <= '0;
            trap       <= 1'b0;
            trap_cause <= 2'b00;
        end else begin
            state <= nextState;
            if (stalled && (nextState == state)) waitCnt <= waitCnt + WAIT_W'(1);
            else                                 waitCnt <= '0;
            if (retire) retired <= retired + RET_W'(1);
            if ((nextState == TRAP) && (state != TRAP)) begin
                trap       <= 1'b1;
                trap_cause <= entryCause;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: a per-cycle vector table for the main instruction
// flows plus hand sequences for trap hold, memory timeout and retired-counter wrap.
module tb_multicycle_control_fsm;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1110011;

    // {mem_req, adr_src, ir_write, mem_write, reg_write, pc_write, result_src, alu_src_a, alu_src_b, alu_op}
    localparam logic [13:0] C_FETCH_R  = 14'b101001_10_00_10_00;
    localparam logic [13:0] C_FETCH_S  = 14'b100000_10_00_10_00;
    localparam logic [13:0] C_FETCH_0  = 14'b000000_10_00_10_00;
    localparam logic [13:0] C_DECODE   = 14'b000000_00_01_01_00;
    localparam logic [13:0] C_MEMADR   = 14'b000000_00_10_01_00;
    localparam logic [13:0] C_MEMREAD  = 14'b110000_00_00_00_00;
    localparam logic [13:0] C_MEMWB    = 14'b000010_01_00_00_00;
    localparam logic [13:0] C_MEMWR_R  = 14'b110100_00_00_00_00;
    localparam logic [13:0] C_MEMWR_S  = 14'b110000_00_00_00_00;
    localparam logic [13:0] C_EXECR    = 14'b000000_00_10_00_10;
    localparam logic [13:0] C_EXECI    = 14'b000000_00_10_01_10;
    localparam logic [13:0] C_ALUWB    = 14'b000010_00_00_00_00;
    localparam logic [13:0] C_BEQ_T    = 14'b000001_00_10_00_01;
    localparam logic [13:0] C_BEQ_N    = 14'b000000_00_10_00_01;
    localparam logic [13:0] C_JAL      = 14'b000001_00_01_10_00;
    localparam logic [13:0] C_TRAP     = 14'b000000_00_00_00_00;

    typedef struct packed {
        logic       rstN;
        logic [6:0] op;
        logic       zero;
        logic       rdy;
        logic [13:0] ctl;
        logic [1:0] imm;
        logic       trap;
        logic [1:0] cause;
        logic [3:0] ret;
    } vecT;

    logic       clk;
    logic       rst;
    logic [6:0] op;
    logic       zero;
    logic       memReady;
    logic       memReq, adrSrc, irWrite, memWrite, regWrite, pcWrite;
    logic [1:0] resultSrc, aluSrcA, aluSrcB, aluOp, immSrc;
    logic       trap;
    logic [1:0] trapCause;
    logic [3:0] retired;

    int  checks   = 0;
    int  failures = 0;
    vecT vecs[$];

    multicycle_control_fsm #(.WAIT_LIMIT(4), .RET_W(4)) dut (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(memReady),
        .mem_req(memReq), .adr_src(adrSrc), .ir_write(irWrite), .mem_write(memWrite),
        .reg_write(regWrite), .pc_write(pcWrite), .result_src(resultSrc),
        .alu_src_a(aluSrcA), .alu_src_b(aluSrcB), .alu_op(aluOp), .imm_src(immSrc),
        .trap(trap), .trap_cause(trapCause), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vecT mk(input logic r, input logic [6:0] o, input logic z, input logic m,
                               input logic [13:0] c, input logic [1:0] i, input logic t,
                               input logic [1:0] ca, input logic [3:0] rt);
        vecT v;
        v.rstN = r;  v.op = o;   v.zero = z;   v.rdy = m;
        v.ctl  = c;  v.imm = i;  v.trap = t;   v.cause = ca;  v.ret = rt;
        return v;
    endfunction

    function automatic logic [22:0] actual();
        return {memReq, adrSrc, irWrite, memWrite, regWrite, pcWrite,
                resultSrc, aluSrcA, aluSrcB, aluOp, immSrc, trap, trapCause, retired};
    endfunction

    task automatic applyStimulus(input logic r, input logic [6:0] o, input logic z, input logic m);
        rst = r;  op = o;  zero = z;  memReady = m;
    endtask

    task automatic checkOutput(input string name, input logic [22:0] act, input logic [22:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply inputs, sample mid-cycle, then advance just past the next rising edge
    task automatic cycleCheck(input string name, input logic r, input logic [6:0] o, input logic z,
                              input logic m, input logic [22:0] exp);
        applyStimulus(r, o, z, m);
        @(negedge clk);
        checkOutput(name, actual(), exp);
        @(posedge clk);
        #1;
    endtask

    task automatic cycleNoCheck(input logic r, input logic [6:0] o, input logic m);
        applyStimulus(r, o, 1'b0, m);
        @(posedge clk);
        #1;
    endtask

    task automatic fillTable();
        vecs.push_back(mk(0, OP_R,   0, 1, C_FETCH_0, 2'b00, 0, 2'b00, 4'd0));
        vecs.push_back(mk(1, OP_R,   0, 1, C_FETCH_R, 2'b00, 0, 2'b00, 4'd0));
        vecs.push_back(mk(1, OP_R,   0, 1, C_DECODE,  2'b00, 0, 2'b00, 4'd0));
        vecs.push_back(mk(1, OP_R,   0, 1, C_EXECR,   2'b00, 0, 2'b00, 4'd0));
        vecs.push_back(mk(1, OP_R,   0, 1, C_ALUWB,   2'b00, 0, 2'b00, 4'd0));
        vecs.push_back(mk(1, OP_LW,  0, 1, C_FETCH_R, 2'b00, 0, 2'b00, 4'd1));
        vecs.push_back(mk(1, OP_LW,  0, 1, C_DECODE,  2'b00, 0, 2'b00, 4'd1));
        vecs.push_back(mk(1, OP_LW,  0, 1, C_MEMADR,  2'b00, 0, 2'b00, 4'd1));
        vecs.push_back(mk(1, OP_LW,  0, 0, C_MEMREAD, 2'b00, 0, 2'b00, 4'd1));
        vecs.push_back(mk(1, OP_LW,  0, 0, C_MEMREAD, 2'b00, 0, 2'b00, 4'd1));
        vecs.push_back(mk(1, OP_LW,  0, 0, C_MEMREAD, 2'b00, 0, 2'b00, 4'd1));
        vecs.push_back(mk(1, OP_LW,  0, 1, C_MEMREAD, 2'b00, 0, 2'b00, 4'd1));
        vecs.push_back(mk(1, OP_LW,  0, 1, C_MEMWB,   2'b00, 0, 2'b00, 4'd1));
        vecs.push_back(mk(1, OP_BEQ, 1, 1, C_FETCH_R, 2'b10, 0, 2'b00, 4'd2));
        vecs.push_back(mk(1, OP_BEQ, 1, 1, C_DECODE,  2'b10, 0, 2'b00, 4'd2));
        vecs.push_back(mk(1, OP_BEQ, 1, 1, C_BEQ_T,   2'b10, 0, 2'b00, 4'd2));
        vecs.push_back(mk(1, OP_BEQ, 0, 1, C_FETCH_R, 2'b10, 0, 2'b00, 4'd3));
        vecs.push_back(mk(1, OP_BEQ, 0, 1, C_DECODE,  2'b10, 0, 2'b00, 4'd3));
        vecs.push_back(mk(1, OP_BEQ, 0, 1, C_BEQ_N,   2'b10, 0, 2'b00, 4'd3));
        vecs.push_back(mk(1, OP_SW,  0, 1, C_FETCH_R, 2'b01, 0, 2'b00, 4'd4));
        vecs.push_back(mk(1, OP_SW,  0, 1, C_DECODE,  2'b01, 0, 2'b00, 4'd4));
        vecs.push_back(mk(1, OP_SW,  0, 1, C_MEMADR,  2'b01, 0, 2'b00, 4'd4));
        vecs.push_back(mk(1, OP_SW,  0, 0, C_MEMWR_S, 2'b01, 0, 2'b00, 4'd4));
        vecs.push_back(mk(1, OP_SW,  0, 1, C_MEMWR_R, 2'b01, 0, 2'b00, 4'd4));
        vecs.push_back(mk(1, OP_I,   0, 1, C_FETCH_R, 2'b00, 0, 2'b00, 4'd5));
        vecs.push_back(mk(1, OP_I,   0, 1, C_DECODE,  2'b00, 0, 2'b00, 4'd5));
        vecs.push_back(mk(1, OP_I,   0, 1, C_EXECI,   2'b00, 0, 2'b00, 4'd5));
        vecs.push_back(mk(1, OP_I,   0, 1, C_ALUWB,   2'b00, 0, 2'b00, 4'd5));
        vecs.push_back(mk(1, OP_JAL, 0, 1, C_FETCH_R, 2'b11, 0, 2'b00, 4'd6));
        vecs.push_back(mk(1, OP_JAL, 0, 1, C_DECODE,  2'b11, 0, 2'b00, 4'd6));
        vecs.push_back(mk(1, OP_JAL, 0, 1, C_JAL,     2'b11, 0, 2'b00, 4'd6));
        vecs.push_back(mk(1, OP_JAL, 0, 1, C_ALUWB,   2'b11, 0, 2'b00, 4'd6));
        vecs.push_back(mk(1, OP_R,   0, 0, C_FETCH_S, 2'b00, 0, 2'b00, 4'd7));
        vecs.push_back(mk(1, OP_R,   0, 1, C_FETCH_R, 2'b00, 0, 2'b00, 4'd7));
        vecs.push_back(mk(1, OP_R,   0, 1, C_DECODE,  2'b00, 0, 2'b00, 4'd7));
        vecs.push_back(mk(0, OP_R,   0, 1, C_EXECR,   2'b00, 0, 2'b00, 4'd7));
        vecs.push_back(mk(1, OP_R,   0, 1, C_FETCH_R, 2'b00, 0, 2'b00, 4'd0));
        vecs.push_back(mk(1, OP_R,   0, 1, C_DECODE,  2'b00, 0, 2'b00, 4'd0));
        vecs.push_back(mk(1, OP_R,   0, 1, C_EXECR,   2'b00, 0, 2'b00, 4'd0));
        vecs.push_back(mk(1, OP_R,   0, 1, C_ALUWB,   2'b00, 0, 2'b00, 4'd0));
        vecs.push_back(mk(1, OP_BAD, 0, 1, C_FETCH_R, 2'b00, 0, 2'b00, 4'd1));
        vecs.push_back(mk(1, OP_BAD, 0, 1, C_DECODE,  2'b00, 0, 2'b00, 4'd1));
        vecs.push_back(mk(1, OP_BAD, 0, 1, C_TRAP,    2'b00, 1, 2'b01, 4'd1));
    endtask

    initial begin
        applyStimulus(1'b0, OP_R, 1'b0, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;

        fillTable();
        foreach (vecs[k]) begin
            cycleCheck($sformatf("vec%0d", k), vecs[k].rstN, vecs[k].op, vecs[k].zero, vecs[k].rdy,
                       {vecs[k].ctl, vecs[k].imm, vecs[k].trap, vecs[k].cause, vecs[k].ret});
        end

        // Trap is sticky whatever the handshake inputs do
        for (int i = 0; i < 20; i++) begin
            cycleCheck($sformatf("trapHold%0d", i), 1'b1, OP_BAD, 1'($urandom_range(1)),
                       1'($urandom_range(1)), {C_TRAP, 2'b00, 1'b1, 2'b01, 4'd1});
        end
        cycleCheck("trapReset", 1'b0, OP_R, 1'b0, 1'b1, {C_TRAP, 2'b00, 1'b1, 2'b01, 4'd1});
        cycleCheck("afterTrapReset", 1'b1, OP_R, 1'b0, 1'b1, {C_FETCH_R, 2'b00, 1'b0, 2'b00, 4'd0});

        // Fetch stalled past the limit: four increments, trap on the fifth stalled cycle
        cycleNoCheck(1'b0, OP_R, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycleCheck($sformatf("timeoutStall%0d", i), 1'b1, OP_R, 1'b0, 1'b0,
                       {C_FETCH_S, 2'b00, 1'b0, 2'b00, 4'd0});
        end
        cycleCheck("timeoutTrap", 1'b1, OP_R, 1'b0, 1'b1, {C_TRAP, 2'b00, 1'b1, 2'b10, 4'd0});

        // Ready on the limit cycle completes the fetch instead of trapping
        cycleNoCheck(1'b0, OP_R, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycleCheck($sformatf("limitStall%0d", i), 1'b1, OP_R, 1'b0, 1'b0,
                       {C_FETCH_S, 2'b00, 1'b0, 2'b00, 4'd0});
        end
        cycleCheck("limitReady", 1'b1, OP_R, 1'b0, 1'b1, {C_FETCH_R, 2'b00, 1'b0, 2'b00, 4'd0});
        cycleCheck("limitDecode", 1'b1, OP_R, 1'b0, 1'b1, {C_DECODE, 2'b00, 1'b0, 2'b00, 4'd0});

        // 4-bit retired counter wraps 15 -> 0 -> 1 over 17 adds
        cycleNoCheck(1'b0, OP_R, 1'b1);
        for (int n = 1; n <= 17; n++) begin
            for (int c = 0; c < 4; c++) cycleNoCheck(1'b1, OP_R, 1'b1);
            if (n == 15 || n == 16 || n == 17) begin
                cycleCheck($sformatf("wrapAfter%0d", n), 1'b1, OP_R, 1'b0, 1'b1,
                           {C_FETCH_R, 2'b00, 1'b0, 2'b00, 4'(n % 16)});
                for (int c = 0; c < 3; c++) cycleNoCheck(1'b1, OP_R, 1'b1);
                rst = 1'b0;
                @(posedge clk);
                #1;
                rst = 1'b1;
                if (n != 17) begin
                    for (int m = 0; m < n; m++) begin
                        for (int c = 0; c < 4; c++) cycleNoCheck(1'b1, OP_R, 1'b1);
                    end
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
